// File: rtl/cpu_types_pkg.sv
// Shared CPU types: word type, fetch FSM states and the bubble encoding.
package cpu_types_pkg;

    localparam int unsigned WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        HALT
    } fetch_state_t;

    localparam word_t NOP_INSTR = 32'h0000_0000;

    // Clear the byte offset so every fetch address is word aligned.
    function automatic word_t word_align(input word_t a);
        return a & ~word_t'(3);
    endfunction

endpackage

// File: rtl/if_id_latch.sv
// IF/ID pipeline latch: flush to a bubble, load a fetched word, otherwise hold.
module if_id_latch
    import cpu_types_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  logic  load,
    input  logic  flush,
    input  word_t load_instr,
    input  word_t load_pc,
    output word_t instr,
    output word_t pc_out,
    output logic  instr_valid
);

    // Flush wins over load; pc_out keeps its last value across bubbles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr       <= NOP_INSTR;
            pc_out      <= '0;
            instr_valid <= 1'b0;
        end else if (flush) begin
            instr       <= NOP_INSTR;
            instr_valid <= 1'b0;
        end else if (load) begin
            instr       <= load_instr;
            pc_out      <= load_pc;
            instr_valid <= 1'b1;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, icache request FSM and IF/ID latch.
// Define FETCH_BUF_EN to add a one-entry buffer that keeps a word hit during a stall.
module fetch_unit
    import cpu_types_pkg::*;
#(
    parameter word_t PC_INIT = 32'h0000_0000
) (
    input  logic  CLK,
    input  logic  nRST,
    input  logic  ihit,
    input  word_t iload,
    output logic  iREN,
    output word_t iaddr,
    input  logic  stall,
    input  logic  redirect,
    input  word_t redirect_pc,
    input  logic  halt,
    output word_t instr,
    output word_t pc_out,
    output word_t pc_plus4,
    output logic  instr_valid
);

    fetch_state_t state, state_nxt;
    word_t        pc, pc_nxt;
    logic         latch_load, latch_flush;
    word_t        load_instr, load_pc;

`ifdef FETCH_BUF_EN
    word_t buf_instr, buf_pc;
    logic  buf_valid;
    logic  buf_capture, buf_drain, buf_clear;

    // One-entry buffer holding a word that arrived while decode was stalled.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            buf_instr <= NOP_INSTR;
            buf_pc    <= '0;
            buf_valid <= 1'b0;
        end else if (buf_clear || buf_drain) begin
            buf_valid <= 1'b0;
        end else if (buf_capture) begin
            buf_instr <= iload;
            buf_pc    <= pc;
            buf_valid <= 1'b1;
        end
    end
`endif

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    state_nxt = FETCH;
            FETCH:   if (!redirect && !stall && halt) state_nxt = HALT;
            HALT:    if (redirect) state_nxt = FETCH;
            default: state_nxt = IDLE;
        endcase
    end

    // Priority: redirect > stall > halt > (buffered word) > ihit.
    always_comb begin
        iREN        = 1'b0;
        latch_load  = 1'b0;
        latch_flush = 1'b0;
        load_instr  = iload;
        load_pc     = pc;
        pc_nxt      = pc;
`ifdef FETCH_BUF_EN
        buf_capture = 1'b0;
        buf_drain   = 1'b0;
        buf_clear   = 1'b0;
        iREN        = (state == FETCH) && !buf_valid;
`else
        iREN        = (state == FETCH);
`endif
        if (redirect) begin
            pc_nxt      = word_align(redirect_pc);
            latch_flush = 1'b1;
`ifdef FETCH_BUF_EN
            buf_clear   = 1'b1;
`endif
        end else if (state == FETCH) begin
            if (stall) begin
`ifdef FETCH_BUF_EN
                if (ihit && !buf_valid) begin
                    buf_capture = 1'b1;
                    pc_nxt      = pc + 32'd4;
                end
`endif
            end else if (halt) begin
                latch_flush = 1'b1;
`ifdef FETCH_BUF_EN
            end else if (buf_valid) begin
                latch_load = 1'b1;
                load_instr = buf_instr;
                load_pc    = buf_pc;
                buf_drain  = 1'b1;
`endif
            end else if (ihit) begin
                latch_load = 1'b1;
                pc_nxt     = pc + 32'd4;
            end else begin
                latch_flush = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) pc <= PC_INIT;
        else       pc <= pc_nxt;
    end

    assign iaddr    = word_align(pc);
    assign pc_plus4 = pc_out + 32'd4;

    if_id_latch u_if_id_latch (
        .clk         (CLK),
        .rst_n       (nRST),
        .load        (latch_load),
        .flush       (latch_flush),
        .load_instr  (load_instr),
        .load_pc     (load_pc),
        .instr       (instr),
        .pc_out      (pc_out),
        .instr_valid (instr_valid)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed plan followed by random traffic vs. a behavioural model.
module tb_fetch_unit;

    localparam logic [31:0] PC_INIT = 32'h0000_0000;
`ifdef FETCH_BUF_EN
    localparam bit BUF = 1'b1;
`else
    localparam bit BUF = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        nRST;
    logic        ihit, stall, redirect, halt;
    logic [31:0] iload, redirect_pc;
    logic        iREN, instr_valid;
    logic [31:0] iaddr, instr, pc_out, pc_plus4;

    int tests = 0;
    int fails = 0;

    // Behavioural model of the fetch stage
    bit          m_started, m_halted, m_bvalid, m_valid;
    logic [31:0] m_pc, m_instr, m_pcout, m_binstr, m_bpc;

    always #5 CLK = ~CLK;

    fetch_unit #(.PC_INIT(PC_INIT)) dut (
        .CLK(CLK), .nRST(nRST), .ihit(ihit), .iload(iload), .iREN(iREN), .iaddr(iaddr),
        .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc), .halt(halt),
        .instr(instr), .pc_out(pc_out), .pc_plus4(pc_plus4), .instr_valid(instr_valid)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_started = 0; m_halted = 0; m_bvalid = 0;
        m_pc = PC_INIT; m_instr = 0; m_pcout = 0; m_valid = 0;
        m_binstr = 0; m_bpc = 0;
    endtask

    function automatic bit model_req();
        return m_started && !m_halted && !(BUF && m_bvalid);
    endfunction

    task automatic model_edge();
        if (redirect) begin
            m_pc = redirect_pc & 32'hFFFF_FFFC;
            m_instr = 0; m_valid = 0; m_bvalid = 0;
            m_started = 1; m_halted = 0;
        end else if (!m_started) begin
            m_started = 1;
        end else if (m_halted) begin
            // frozen until redirect
        end else if (stall) begin
            if (BUF && ihit && !m_bvalid) begin
                m_binstr = iload; m_bpc = m_pc; m_bvalid = 1; m_pc = m_pc + 4;
            end
        end else if (halt) begin
            m_halted = 1; m_instr = 0; m_valid = 0;
        end else if (BUF && m_bvalid) begin
            m_instr = m_binstr; m_pcout = m_bpc; m_valid = 1; m_bvalid = 0;
        end else if (ihit) begin
            m_instr = iload; m_pcout = m_pc; m_valid = 1; m_pc = m_pc + 4;
        end else begin
            m_instr = 0; m_valid = 0;
        end
    endtask

    task automatic check_outputs();
        check("instr", instr, m_instr);
        check("pc_out", pc_out, m_pcout);
        check("pc_plus4", pc_plus4, m_pcout + 32'd4);
        check("instr_valid", 32'(instr_valid), 32'(m_valid));
    endtask

    // One clock: drive inputs, check the request, clock, check the latch.
    task automatic step(input logic h, input logic [31:0] d, input logic s,
                        input logic r, input logic [31:0] rpc, input logic hl);
        ihit = h; iload = d; stall = s; redirect = r; redirect_pc = rpc; halt = hl;
        #1;
        check("iREN", 32'(iREN), 32'(model_req()));
        check("iaddr", iaddr, m_pc);
        @(posedge CLK);
        model_edge();
        #1;
        check_outputs();
    endtask

    task automatic idle_step();
        step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    endtask

    initial begin
        nRST = 1'b0; ihit = 0; iload = 0; stall = 0; redirect = 0; redirect_pc = 0; halt = 0;
        model_reset();
        #1;
        check("rst_iREN", 32'(iREN), 32'h0);
        check("rst_iaddr", iaddr, PC_INIT);
        check_outputs();
        @(posedge CLK); @(posedge CLK); #1;
        nRST = 1'b1;

        // Leave IDLE, then back-to-back hits
        idle_step();
        step(1'b1, 32'h00A0_0093, 1'b0, 1'b0, 32'h0, 1'b0);
        check("plan_pc_out0", pc_out, 32'h0);
        step(1'b1, 32'h0010_0113, 1'b0, 1'b0, 32'h0, 1'b0);
        check("plan_pc_plus4_1", pc_plus4, 32'h8);

        // Misses at pc=8
        repeat (3) idle_step();
        check("plan_miss_iaddr", iaddr, 32'h8);
        step(1'b1, 32'h1111_1111, 1'b0, 1'b0, 32'h0, 1'b0);
        check("plan_after_miss_pc", pc_out, 32'h8);

        // Stall with hits at pc=12
        step(1'b1, 32'h2222_2222, 1'b1, 1'b0, 32'h0, 1'b0);
        step(1'b1, 32'h3333_3333, 1'b1, 1'b0, 32'h0, 1'b0);
        check("plan_stall_hold", instr, 32'h1111_1111);
        check("plan_stall_iaddr", iaddr, BUF ? 32'h10 : 32'hC);
        step(1'b1, 32'h4444_4444, 1'b0, 1'b0, 32'h0, 1'b0);
        check("plan_release_pc", pc_out, 32'hC);

        // Redirect wins over stall and ihit
        step(1'b1, 32'h5555_5555, 1'b1, 1'b1, 32'h0000_0103, 1'b0);
        check("plan_redir_iaddr", iaddr, 32'h100);
        step(1'b1, 32'h6666_6666, 1'b0, 1'b0, 32'h0, 1'b0);
        check("plan_redir_pc", pc_out, 32'h100);

        // PC wrap at top of address space
        step(1'b0, 32'h0, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0);
        step(1'b1, 32'h7777_7777, 1'b0, 1'b0, 32'h0, 1'b0);
        check("plan_wrap_plus4", pc_plus4, 32'h0);
        check("plan_wrap_iaddr", iaddr, 32'h0);

        // Halt at pc=20, sticky for 10 cycles, then redirect out
        step(1'b0, 32'h0, 1'b0, 1'b1, 32'h14, 1'b0);
        step(1'b1, 32'h8888_8888, 1'b0, 1'b0, 32'h0, 1'b1);
        for (int i = 0; i < 10; i++) step(1'($urandom), $urandom, 1'b0, 1'b0, 32'h0, 1'($urandom));
        check("plan_halt_iaddr", iaddr, 32'h14);
        check("plan_halt_iREN", 32'(iREN), 32'h0);
        step(1'b0, 32'h0, 1'b0, 1'b1, 32'h40, 1'b0);
        check("plan_unhalt_iREN", 32'(iREN), 32'h1);
        check("plan_unhalt_iaddr", iaddr, 32'h40);

        // Reset in the middle of a waiting request at pc=24
        step(1'b0, 32'h0, 1'b0, 1'b1, 32'h18, 1'b0);
        idle_step();
        #2;
        nRST = 1'b0;
        #1;
        model_reset();
        check("midrst_iREN", 32'(iREN), 32'h0);
        check("midrst_iaddr", iaddr, PC_INIT);
        check_outputs();
        @(posedge CLK); #1;
        nRST = 1'b1;
        idle_step();
        check("post_rst_iaddr", iaddr, PC_INIT);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            step(1'($urandom_range(0, 3) != 0), $urandom,
                 1'($urandom_range(0, 3) == 0),
                 1'($urandom_range(0, 11) == 0), $urandom,
                 1'($urandom_range(0, 19) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
